// File: rtl/scrypt_pkg.sv
// Shared types and widths for the scrypt nonce-sweep logic.
package scrypt_pkg;

  localparam int HEADER_W  = 640;
  localparam int HASH_W    = 256;
  localparam int NONCE_W   = 32;
  localparam int NONCE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } nonce_ctrl_state_t;

  // Overwrite the nonce field of a header with the given nonce.
  function automatic logic [HEADER_W-1:0] insert_nonce(
    input logic [HEADER_W-1:0] hdr,
    input logic [NONCE_W-1:0]  nonce_val
  );
    logic [HEADER_W-1:0] res;
    res = hdr;
    res[NONCE_LSB +: NONCE_W] = nonce_val;
    return res;
  endfunction

endpackage

// File: rtl/scrypt_target_cmp.sv
// Registered 256-bit unsigned hash <= target comparator. Kept as its own
// block so the wide compare can be retimed independently of the sequencer.
module scrypt_target_cmp
  import scrypt_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic              le
);

  logic le_r;

  // Capture the compare outcome whenever a fresh hash is presented.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      le_r <= 1'b0;
    end else if (en) begin
      le_r <= (hash <= target);
    end
  end

  assign le = le_r;

endmodule

// File: rtl/scrypt_nonce_ctrl.sv
// Nonce-sweep sequencer: inserts each nonce of a range into the header,
// launches one scrypt hash per nonce and stops on the first hash <= target,
// on range exhaustion, on watchdog expiry or on abort.
module scrypt_nonce_ctrl
  import scrypt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [HEADER_W-1:0] header,
  input  logic [HASH_W-1:0]   target,
  input  logic [NONCE_W-1:0]  nonce_first,
  input  logic [NONCE_W-1:0]  nonce_last,
  output logic [HEADER_W-1:0] core_data,
  output logic                core_start,
  input  logic                core_done,
  input  logic [HASH_W-1:0]   core_hash,
  output logic                busy,
  output logic [NONCE_W-1:0]  nonce,
  output logic                match_found,
  output logic                timeout,
  output logic                hash_done,
  output logic [31:0]         hashes_tried
);

  // Last RUN count value before the watchdog fires.
  localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam bit          WD_EN   = (TIMEOUT_CYCLES > 0);

  nonce_ctrl_state_t     state_r, next_state_s;
  logic [HEADER_W-1:0]   hdr_r;
  logic [HASH_W-1:0]     target_r;
  logic [NONCE_W-1:0]    last_r;
  logic [NONCE_W-1:0]    cur_nonce_r;
  logic [31:0]           run_cnt_r;
  logic [HEADER_W-1:0]   core_data_r;
  logic                  core_start_r;
  logic                  busy_r;
  logic [NONCE_W-1:0]    nonce_r;
  logic                  match_r;
  logic                  timeout_r;
  logic                  hash_done_r;
  logic [31:0]           hashes_r;

  logic                  le_s;
  logic                  accept_s;
  logic                  capture_s;
  logic                  expire_s;
  logic                  hit_s;
  logic                  exhaust_s;
  logic [NONCE_W-1:0]    nxt_nonce_s;
  logic [HEADER_W-1:0]   nxt_hdr_s;

  // The compare result is registered together with the hash capture, so it
  // is ready for the CHECK decision one cycle later.
  scrypt_target_cmp u_cmp (
    .clk    (clk),
    .n_rst  (n_rst),
    .en     (capture_s),
    .hash   (core_hash),
    .target (target_r),
    .le     (le_s)
  );

  // Next-state and event decode; abort overrides every other transition.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    expire_s     = 1'b0;
    hit_s        = 1'b0;
    exhaust_s    = 1'b0;
    nxt_nonce_s  = cur_nonce_r;
    nxt_hdr_s    = hdr_r;
    if (abort) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            accept_s     = 1'b1;
            nxt_nonce_s  = nonce_first;
            nxt_hdr_s    = header;
            next_state_s = ST_LOAD;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          next_state_s = ST_RUN;
        end
        ST_RUN: begin
          // A completion in the expiry cycle still counts as a real hash.
          if (core_done) begin
            capture_s    = 1'b1;
            next_state_s = ST_CHECK;
          end else if (WD_EN && (run_cnt_r == WD_LAST)) begin
            expire_s     = 1'b1;
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_CHECK: begin
          if (le_s) begin
            hit_s        = 1'b1;
            next_state_s = ST_DONE;
          end else if (cur_nonce_r == last_r) begin
            exhaust_s    = 1'b1;
            next_state_s = ST_DONE;
          end else begin
            nxt_nonce_s  = cur_nonce_r + 32'd1;
            next_state_s = ST_LOAD;
          end
        end
        ST_DONE: begin
          next_state_s = ST_IDLE;
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, sweep context and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= ST_IDLE;
      hdr_r        <= '0;
      target_r     <= '0;
      last_r       <= 32'd0;
      cur_nonce_r  <= 32'd0;
      run_cnt_r    <= 32'd0;
      core_data_r  <= '0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      nonce_r      <= 32'd0;
      match_r      <= 1'b0;
      timeout_r    <= 1'b0;
      hash_done_r  <= 1'b0;
      hashes_r     <= 32'd0;
    end else begin
      state_r      <= next_state_s;
      cur_nonce_r  <= nxt_nonce_s;
      core_start_r <= (next_state_s == ST_LOAD);
      busy_r       <= (next_state_s != ST_IDLE);
      hash_done_r  <= (next_state_s == ST_DONE);
      // Watchdog counts RUN cycles of the current hash only.
      if ((state_r == ST_RUN) && (next_state_s == ST_RUN)) begin
        run_cnt_r <= run_cnt_r + 32'd1;
      end else begin
        run_cnt_r <= 32'd0;
      end
      // core_data only changes on entry to LOAD, so it is stable through RUN.
      if (next_state_s == ST_LOAD) begin
        core_data_r <= insert_nonce(nxt_hdr_s, nxt_nonce_s);
      end
      if (accept_s) begin
        hdr_r     <= header;
        target_r  <= target;
        last_r    <= nonce_last;
        match_r   <= 1'b0;
        timeout_r <= 1'b0;
        hashes_r  <= 32'd0;
      end
      if (capture_s) begin
        hashes_r <= hashes_r + 32'd1;
      end
      if (hit_s) begin
        match_r <= 1'b1;
        nonce_r <= cur_nonce_r;
      end
      if (exhaust_s) begin
        nonce_r <= cur_nonce_r;
      end
      if (expire_s) begin
        timeout_r <= 1'b1;
        nonce_r   <= cur_nonce_r;
      end
    end
  end

  assign core_data    = core_data_r;
  assign core_start   = core_start_r;
  assign busy         = busy_r;
  assign nonce        = nonce_r;
  assign match_found  = match_r;
  assign timeout      = timeout_r;
  assign hash_done    = hash_done_r;
  assign hashes_tried = hashes_r;

endmodule

// File: doc/scrypt_nonce_ctrl.md
# scrypt_nonce_ctrl

Nonce-sweep sequencer for the scrypt hashing pipeline. It latches an 80-byte block header, a 256-bit target and a nonce range. For each nonce it inserts the value into the header, launches one hash on the scrypt core (PBKDF2 → SMix → PBKDF2 chain), and compares the returned 256-bit hash against the target. The sweep stops on the first match, on range exhaustion, or on abort, and the result is reported to the host-side logic.

## Interface
- `TIMEOUT_CYCLES`, default 0: maximum cycles spent in RUN per hash. 0 disables the watchdog.
- `clk` in 1: system clock. All logic is on the rising edge.
- `n_rst` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a sweep. Honoured only in IDLE.
- `abort` in 1: cancel a sweep. Has priority over `start`.
- `header` in 640: block header. The nonce field is bits [31:0] and is overwritten by the block.
- `target` in 256: unsigned threshold. A hash matches when hash ≤ target.
- `nonce_first` in 32: first nonce of the range.
- `nonce_last` in 32: last nonce of the range, inclusive.
- `core_data` out 640: latched header with the current nonce in bits [31:0].
- `core_start` out 1: one-cycle launch pulse to the scrypt core.
- `core_done` in 1: one-cycle completion pulse from the core.
- `core_hash` in 256: core result. Valid only when `core_done`=1.
- `busy` out 1: high in every state except IDLE.
- `nonce` out 32: winning nonce, or the last nonce tried.
- `match_found` out 1: result flag. Held until the next accepted `start`.
- `timeout` out 1: the sweep ended on a watchdog expiry. Held like `match_found`.
- `hash_done` out 1: one-cycle pulse at sweep end. Not asserted on abort.
- `hashes_tried` out 32: count of completed core hashes in the current sweep.

## Operation
- FSM states: IDLE, LOAD, RUN, CHECK, DONE.
- IDLE, `start`=1:
  - Latch `header`, `target`, `nonce_first` and `nonce_last`.
  - Set cur_nonce = `nonce_first`.
  - Clear `match_found`, `timeout` and `hashes_tried`.
  - Go to LOAD.
- LOAD:
  - Assert `core_start` for exactly this cycle.
  - `core_data` = {hdr[639:32], cur_nonce}. `core_data` is held stable from LOAD until leaving RUN.
  - Go to RUN.
- RUN: wait for `core_done`. On `core_done`:
  - Register `core_hash`.
  - Increment `hashes_tried`. The increment wraps modulo 2^32.
  - Go to CHECK.
- CHECK: compare the registered hash ≤ target as a full 256-bit unsigned compare.
  - If it matches: `match_found`←1, `nonce`←cur_nonce, go to DONE.
  - Else if cur_nonce == last: `nonce`←cur_nonce, go to DONE.
  - Else: cur_nonce←cur_nonce+1 (modulo 2^32), go to LOAD.
- DONE: assert `hash_done` for one cycle, then go to IDLE.
- Range wrap: if last < first, the sweep wraps from FFFF_FFFF to 0000_0000 and ends at last.
- Single-nonce range: if first == last, exactly one hash is run.
- Watchdog: when `TIMEOUT_CYCLES`>0 and RUN lasts `TIMEOUT_CYCLES` cycles without `core_done`:
  - `timeout`←1, `nonce`←cur_nonce, go to DONE.
  - `hashes_tried` is unchanged.
- `abort`, in any state: next state is IDLE and `core_start` is 0 that cycle.
  - `match_found`, `timeout` and `nonce` keep their old values.
  - No `hash_done` pulse.
- `start` while `busy`: ignored. `start` and `abort` in the same cycle: abort wins, so the block stays in or returns to IDLE.
- `core_done` outside RUN: ignored, with no state change and no count.
- `core_done` in the same cycle the watchdog expires: `core_done` wins and the hash is checked normally.

## Timing
- Reset values: state=IDLE. All outputs are 0: `core_data`, `core_start`, `busy`, `nonce`, `match_found`, `timeout`, `hash_done`, `hashes_tried`. All internal registers are 0.
- Reset asserted mid-sweep: return to IDLE immediately (asynchronous). No pulse is emitted.
- `start` sampled at edge T:
  - `busy`=1 from T+1.
  - `core_start`=1 during T+1.
- `core_done` sampled at edge K:
  - CHECK runs at K+1.
  - The next `core_start`, or `hash_done`, occurs in cycle K+2.
- Per-nonce overhead beyond core latency: 3 cycles (LOAD, CHECK, plus the done-detect edge).
- `hash_done` cycle: `busy` is still 1. It drops to 0 the following cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared `scrypt_pkg` holds:
  - the state enum `nonce_ctrl_state_t`;
  - `HEADER_W`=640, `HASH_W`=256, `NONCE_W`=32;
  - `NONCE_LSB`=0.
- Sub-module `scrypt_target_cmp`: a registered 256-bit unsigned ≤ comparator. Its inputs are hash and target, and its output is `le`. It is used in CHECK and is kept separate so the compare can be retimed.

## Test plan
- Range 0x10..0x13. The model core returns a hash > target for every nonce. Expect 4 `core_start` pulses, `hash_done`=1, `match_found`=0, `nonce`=0x13, `hashes_tried`=4.
- Range 0x100..0x1FF. The core returns hash=0 for nonce 0x105. Expect `match_found`=1, `nonce`=0x105, `hashes_tried`=6, and no further `core_start`.
- Wrap range first=FFFF_FFFE, last=0000_0001 with no match. Expect `core_data`[31:0] to step FFFF_FFFE, FFFF_FFFF, 0, 1, then `hash_done`, with `hashes_tried`=4.
- Abort in RUN on the second nonce. Expect IDLE next cycle, `busy`=0, no `hash_done`, and a late `core_done` ignored. A subsequent `start` runs normally.
- `TIMEOUT_CYCLES`=50 with a core that never responds. Expect `timeout`=1 and `hash_done` 52 cycles after `start`, `hashes_tried`=0.
- Hash equal to target (boundary). Expect `match_found`=1. Hash = target+1: no match.
